// File: rtl/ext_xfer_engine_pkg.sv
// ext_xfer_engine_pkg
// Shared definitions for the strided transfer engine: default widths,
// direction codes, FSM state encoding and skid FIFO geometry.
package ext_xfer_engine_pkg;

  // Default widths used when the engine is instantiated without overrides.
  localparam int DEF_IO_ADDR_W  = 16;
  localparam int DEF_MEM_ADDR_W = 4;
  localparam int DEF_IO_SIZE_W  = 8;

  // Transfer direction codes; any other value makes a run a no-op.
  localparam logic [1:0] DIR_EXT2INT = 2'b01;
  localparam logic [1:0] DIR_INT2EXT = 2'b10;

  localparam int STATES_W = 2;

  typedef enum logic [STATES_W-1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT2INT = 2'd1,
    ST_INT2EXT = 2'd2,
    ST_DONE    = 2'd3
  } xfer_state_e;

  // Read skid FIFO: two entries cover the one-cycle memory read latency.
  localparam int FIFO_DEPTH = 2;
  localparam int FIFO_PTR_W = 1;
  localparam int FIFO_CNT_W = 2;

endpackage

// File: rtl/ext_xfer_engine_fifo.sv
// xfer_skid_fifo
// Two-entry FIFO that buffers internal memory read data in INT2EXT.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   push, din   write din at the tail
//   pop         drop the head entry
//   flush       discard all entries (has priority over push/pop)
//   dout        head entry (valid when !empty)
//   empty       no entries held
//   count       number of entries held (0..2)
module xfer_skid_fifo
  import ext_xfer_engine_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [DATA_W-1:0]     din,
  output logic [DATA_W-1:0]     dout,
  output logic                  empty,
  output logic [FIFO_CNT_W-1:0] count
);

  logic [DATA_W-1:0]     mem_q [FIFO_DEPTH];
  logic [FIFO_PTR_W-1:0] rd_ptr_q;
  logic [FIFO_PTR_W-1:0] wr_ptr_q;
  logic [FIFO_CNT_W-1:0] count_q;

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + FIFO_PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + FIFO_PTR_W'(1);
      end
      count_q <= count_q + FIFO_CNT_W'(push) - FIFO_CNT_W'(pop);
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/ext_xfer_engine.sv
// ext_xfer_engine
// Strided single-beat transfer engine between the external databus and one
// internal memory port. Both sides walk their address by a signed stride;
// the INT2EXT path hides the memory read latency with a two-entry skid FIFO.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   run, abort                      start strobe (IDLE only), stop request
//   busy, done                      transfer active, one-cycle completion pulse
//   ext_addr/ext_stride             external start address and per-beat step
//   int_addr/int_stride             internal start address and per-word step
//   size, direction                 word count, 01 = EXT2INT, 10 = INT2EXT
//   databus_*                       external bus request/handshake and data
//   req, rnw, addr, data_out,       internal memory port, read data valid one
//   data_in                         cycle after a read request
module ext_xfer_engine
  import ext_xfer_engine_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int IO_ADDR_W  = DEF_IO_ADDR_W,
  parameter int MEM_ADDR_W = DEF_MEM_ADDR_W,
  parameter int IO_SIZE_W  = DEF_IO_SIZE_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         run,
  input  logic                         abort,
  output logic                         busy,
  output logic                         done,
  input  logic [IO_ADDR_W-1:0]         ext_addr,
  input  logic signed [IO_ADDR_W-1:0]  ext_stride,
  input  logic [MEM_ADDR_W-1:0]        int_addr,
  input  logic signed [MEM_ADDR_W-1:0] int_stride,
  input  logic [IO_SIZE_W-1:0]         size,
  input  logic [1:0]                   direction,
  output logic                         databus_valid,
  input  logic                         databus_ready,
  output logic [IO_ADDR_W-1:0]         databus_addr,
  input  logic [DATA_W-1:0]            databus_rdata,
  output logic [DATA_W-1:0]            databus_wdata,
  output logic [DATA_W/8-1:0]          databus_wstrb,
  output logic                         req,
  output logic                         rnw,
  output logic [MEM_ADDR_W-1:0]        addr,
  output logic [DATA_W-1:0]            data_out,
  input  logic [DATA_W-1:0]            data_in
);

  localparam int CNT_W = IO_SIZE_W + 1;

  xfer_state_e           state_q, state_d;
  logic [IO_ADDR_W-1:0]  ext_addr_q, ext_addr_d, ext_stride_q;
  logic [MEM_ADDR_W-1:0] int_addr_q, int_addr_d, int_stride_q;
  logic [CNT_W-1:0]      size_q, size_d;
  logic [CNT_W-1:0]      issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
  logic                  inflight_q, inflight_d;
  logic                  abort_pend_q, abort_pend_d;

  logic                  fifo_push, fifo_pop, fifo_flush, fifo_empty;
  logic [DATA_W-1:0]     fifo_dout;
  logic [FIFO_CNT_W-1:0] fifo_count;
  logic                  start, handshake, abort_req;

  assign start = (state_q == ST_IDLE) && run;

  xfer_skid_fifo #(.DATA_W(DATA_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .din   (data_in),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ext_addr_q   <= '0;
      int_addr_q   <= '0;
      ext_stride_q <= '0;
      int_stride_q <= '0;
      size_q       <= '0;
      issue_cnt_q  <= '0;
      beat_cnt_q   <= '0;
      inflight_q   <= 1'b0;
      abort_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ext_addr_q   <= ext_addr_d;
      int_addr_q   <= int_addr_d;
      size_q       <= size_d;
      issue_cnt_q  <= issue_cnt_d;
      beat_cnt_q   <= beat_cnt_d;
      inflight_q   <= inflight_d;
      abort_pend_q <= abort_pend_d;
      if (start) begin
        ext_stride_q <= ext_stride;
        int_stride_q <= int_stride;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    ext_addr_d    = ext_addr_q;
    int_addr_d    = int_addr_q;
    size_d        = size_q;
    issue_cnt_d   = issue_cnt_q;
    beat_cnt_d    = beat_cnt_q;
    inflight_d    = inflight_q;
    abort_pend_d  = abort_pend_q;
    databus_valid = 1'b0;
    databus_wdata = '0;
    databus_wstrb = '0;
    req           = 1'b0;
    rnw           = 1'b1;
    data_out      = '0;
    fifo_push     = 1'b0;
    fifo_pop      = 1'b0;
    fifo_flush    = 1'b0;
    handshake     = 1'b0;
    abort_req     = abort || abort_pend_q;

    case (state_q)
      ST_IDLE: begin
        abort_pend_d = 1'b0;
        if (run) begin
          ext_addr_d  = ext_addr;
          int_addr_d  = int_addr;
          size_d      = CNT_W'(size);
          issue_cnt_d = '0;
          beat_cnt_d  = '0;
          inflight_d  = 1'b0;
          if (size == '0) begin
            state_d = ST_DONE;
          end else if (direction == DIR_EXT2INT) begin
            state_d = ST_EXT2INT;
          end else if (direction == DIR_INT2EXT) begin
            state_d = ST_INT2EXT;
          end else begin
            state_d = ST_DONE;
          end
        end
      end

      ST_EXT2INT: begin
        databus_valid = (beat_cnt_q < size_q);
        handshake     = databus_valid && databus_ready;
        // Bus read data goes straight to memory in the accepting cycle.
        if (handshake) begin
          req        = 1'b1;
          rnw        = 1'b0;
          data_out   = databus_rdata;
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
          ext_addr_d = ext_addr_q + ext_stride_q;
          int_addr_d = int_addr_q + int_stride_q;
        end
        if (abort_req) begin
          if (!databus_valid || databus_ready) begin
            state_d = ST_DONE;
          end else begin
            abort_pend_d = 1'b1;
          end
        end
        if (beat_cnt_d == size_q) begin
          state_d = ST_DONE;
        end
      end

      ST_INT2EXT: begin
        // A read in flight counts as a buffered word: its data is presented
        // directly from data_in when the FIFO is empty, so the first beat
        // appears one cycle after the first read.
        databus_valid = !fifo_empty || inflight_q;
        databus_wdata = fifo_empty ? data_in : fifo_dout;
        databus_wstrb = '1;
        handshake     = databus_valid && databus_ready;
        fifo_pop      = handshake && !fifo_empty;
        fifo_push     = inflight_q && !(handshake && fifo_empty);
        inflight_d    = 1'b0;
        if ((issue_cnt_q < size_q) &&
            ((fifo_count + FIFO_CNT_W'(inflight_q)) < FIFO_CNT_W'(FIFO_DEPTH)) &&
            !abort_pend_q) begin
          req         = 1'b1;
          issue_cnt_d = issue_cnt_q + CNT_W'(1);
          int_addr_d  = int_addr_q + int_stride_q;
          inflight_d  = 1'b1;
        end
        if (handshake) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
          ext_addr_d = ext_addr_q + ext_stride_q;
        end
        if (abort_req) begin
          if (!databus_valid || databus_ready) begin
            state_d    = ST_DONE;
            fifo_flush = 1'b1;
            inflight_d = 1'b0;
          end else begin
            abort_pend_d = 1'b1;
          end
        end
        if (beat_cnt_d == size_q) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        abort_pend_d = 1'b0;
        state_d      = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign busy         = (state_q == ST_EXT2INT) || (state_q == ST_INT2EXT);
  assign done         = (state_q == ST_DONE);
  assign databus_addr = ext_addr_q;
  assign addr         = int_addr_q;

endmodule

// File: tb/tb_ext_xfer_engine.sv
module tb_ext_xfer_engine;
  import ext_xfer_engine_pkg::*;

  localparam int DATA_W     = 32;
  localparam int IO_ADDR_W  = 16;
  localparam int MEM_ADDR_W = 4;
  localparam int IO_SIZE_W  = 8;

  logic                  clk = 1'b0;
  logic                  rst, run, abort;
  logic                  busy, done;
  logic [IO_ADDR_W-1:0]  ext_addr, ext_stride;
  logic [MEM_ADDR_W-1:0] int_addr, int_stride;
  logic [IO_SIZE_W-1:0]  size;
  logic [1:0]            direction;
  logic                  databus_valid, databus_ready;
  logic [IO_ADDR_W-1:0]  databus_addr;
  logic [DATA_W-1:0]     databus_rdata, databus_wdata;
  logic [DATA_W/8-1:0]   databus_wstrb;
  logic                  req, rnw;
  logic [MEM_ADDR_W-1:0] addr;
  logic [DATA_W-1:0]     data_out, data_in;

  always #5 clk = ~clk;

  ext_xfer_engine #(
    .DATA_W(DATA_W), .IO_ADDR_W(IO_ADDR_W),
    .MEM_ADDR_W(MEM_ADDR_W), .IO_SIZE_W(IO_SIZE_W)
  ) dut (
    .clk(clk), .rst(rst), .run(run), .abort(abort),
    .busy(busy), .done(done),
    .ext_addr(ext_addr), .ext_stride(ext_stride),
    .int_addr(int_addr), .int_stride(int_stride),
    .size(size), .direction(direction),
    .databus_valid(databus_valid), .databus_ready(databus_ready),
    .databus_addr(databus_addr), .databus_rdata(databus_rdata),
    .databus_wdata(databus_wdata), .databus_wstrb(databus_wstrb),
    .req(req), .rnw(rnw), .addr(addr),
    .data_out(data_out), .data_in(data_in)
  );

  // External bus read data is a tag of the beat address.
  assign databus_rdata = {16'hA5A5, databus_addr};

  // Internal memory: preset to C0DE_0000+index on reset, 1-cycle read.
  logic [DATA_W-1:0] mem [2**MEM_ADDR_W];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2**MEM_ADDR_W; i++) mem[i] <= 32'hC0DE_0000 + i;
    end else if (req && !rnw) begin
      mem[addr] <= data_out;
    end
    if (req && rnw) data_in <= mem[addr];
  end

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  typedef struct {
    int          cyc;
    logic [31:0] a;
    logic [31:0] d;
  } ev_t;

  ev_t         beat_q[$];
  ev_t         wr_q[$];
  logic [31:0] rd_q[$];
  int cyc = 0;
  int c0 = 0;
  int done_cnt, done_cyc, valid_seen, req_seen, busy_seen, req_after_done;
  bit mon_en = 1'b0;
  bit rdy_rand = 1'b0;
  bit prev_stall = 1'b0;
  logic [31:0] prev_addr, prev_wdata;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (databus_valid && databus_ready) begin
        beat_q.push_back('{cyc - c0, 32'(databus_addr), databus_wdata});
        $display("beat  cyc=%0d addr=0x%04h rdata=0x%08h wdata=0x%08h",
                 cyc - c0, databus_addr, databus_rdata, databus_wdata);
      end
      if (req && !rnw) begin
        wr_q.push_back('{cyc - c0, 32'(addr), data_out});
        $display("mwr   cyc=%0d addr=%0d data=0x%08h", cyc - c0, addr, data_out);
      end
      if (req && rnw) begin
        rd_q.push_back(32'(addr));
        $display("mrd   cyc=%0d addr=%0d", cyc - c0, addr);
      end
      if (req && done_cnt != 0) req_after_done++;
      if (databus_valid) valid_seen++;
      if (req) req_seen++;
      if (busy) busy_seen++;
      if (mon_en && prev_stall) begin
        check_eq("stall_valid", 32'(databus_valid), 32'd1);
        check_eq("stall_addr", 32'(databus_addr), prev_addr);
        check_eq("stall_wdata", databus_wdata, prev_wdata);
      end
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc - c0;
      $display("done  cyc=%0d", cyc - c0);
    end
    prev_stall = databus_valid && !databus_ready && !rst;
    prev_addr  = 32'(databus_addr);
    prev_wdata = databus_wdata;
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rdy_rand) databus_ready = ($urandom_range(0, 99) < 30);
  endtask

  task automatic start_xfer(input logic [1:0] dir, input logic [15:0] ea, input logic [15:0] es,
                            input logic [3:0] ia, input logic [3:0] is, input logic [7:0] sz);
    beat_q.delete(); wr_q.delete(); rd_q.delete();
    done_cnt = 0; done_cyc = -1; valid_seen = 0; req_seen = 0; busy_seen = 0; req_after_done = 0;
    direction = dir; ext_addr = ea; ext_stride = es; int_addr = ia; int_stride = is; size = sz;
    run = 1'b1;
    c0 = cyc;
    step();
    run = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int bound);
    int n = 0;
    while (done_cnt == 0 && n < bound) begin
      step();
      n++;
    end
    check_eq({tag, "_done_seen"}, 32'(done_cnt != 0), 32'd1);
  endtask

  // Hand-computed expectations.
  logic [31:0] t1_ba [4] = '{32'h100, 32'h102, 32'h104, 32'h106};
  logic [31:0] t1_wa [4] = '{32'd8, 32'd9, 32'd10, 32'd11};
  logic [31:0] t1_wd [4] = '{32'hA5A5_0100, 32'hA5A5_0102, 32'hA5A5_0104, 32'hA5A5_0106};
  logic [31:0] t2_ba [5] = '{32'h200, 32'h201, 32'h202, 32'h203, 32'h204};
  logic [31:0] t2_wd [5] = '{32'hC0DE_0004, 32'hC0DE_0003, 32'hC0DE_0002, 32'hC0DE_0001, 32'hC0DE_0000};
  logic [31:0] t2_ra [5] = '{32'd4, 32'd3, 32'd2, 32'd1, 32'd0};
  logic [31:0] t4_ba [4] = '{32'h300, 32'h2FF, 32'h2FE, 32'h2FD};
  logic [31:0] t4_wa [4] = '{32'd14, 32'd15, 32'd0, 32'd1};
  logic [31:0] t4_wd [4] = '{32'hA5A5_0300, 32'hA5A5_02FF, 32'hA5A5_02FE, 32'hA5A5_02FD};
  logic [31:0] t5_wd [3] = '{32'hC0DE_0005, 32'hC0DE_0006, 32'hC0DE_0007};

  initial begin
    rst = 1'b1; run = 1'b0; abort = 1'b0; databus_ready = 1'b0;
    ext_addr = '0; ext_stride = '0; int_addr = '0; int_stride = '0; size = '0; direction = '0;
    done_cnt = 0; done_cyc = -1; valid_seen = 0; req_seen = 0; busy_seen = 0; req_after_done = 0;
    repeat (3) step();

    // Reset state
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_valid", 32'(databus_valid), 32'd0);
    check_eq("rst_req", 32'(req), 32'd0);
    check_eq("rst_rnw", 32'(rnw), 32'd1);
    check_eq("rst_daddr", 32'(databus_addr), 32'd0);
    check_eq("rst_addr", 32'(addr), 32'd0);
    check_eq("rst_wstrb", 32'(databus_wstrb), 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    step();

    // EXT2INT, ready held high
    databus_ready = 1'b1;
    start_xfer(DIR_EXT2INT, 16'h100, 16'h2, 4'd8, 4'd1, 8'd4);
    wait_done("t1", 20);
    repeat (2) step();
    check_eq("t1_nbeats", 32'(beat_q.size()), 32'd4);
    check_eq("t1_nwr", 32'(wr_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < beat_q.size()) begin
        check_eq("t1_beat_cyc", 32'(beat_q[i].cyc), 32'(i + 1));
        check_eq("t1_beat_addr", beat_q[i].a, t1_ba[i]);
      end
      if (i < wr_q.size()) begin
        check_eq("t1_wr_addr", wr_q[i].a, t1_wa[i]);
        check_eq("t1_wr_data", wr_q[i].d, t1_wd[i]);
      end
    end
    check_eq("t1_done_cnt", 32'(done_cnt), 32'd1);
    check_eq("t1_done_cyc", 32'(done_cyc), 32'd5);

    // INT2EXT, random ready, negative internal stride
    rdy_rand = 1'b1;
    start_xfer(DIR_INT2EXT, 16'h200, 16'h1, 4'd4, 4'hF, 8'd5);
    wait_done("t2", 300);
    rdy_rand = 1'b0;
    databus_ready = 1'b0;
    repeat (3) step();
    check_eq("t2_nbeats", 32'(beat_q.size()), 32'd5);
    check_eq("t2_nrd", 32'(rd_q.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < beat_q.size()) begin
        check_eq("t2_beat_addr", beat_q[i].a, t2_ba[i]);
        check_eq("t2_beat_wdata", beat_q[i].d, t2_wd[i]);
      end
      if (i < rd_q.size()) check_eq("t2_rd_addr", rd_q[i], t2_ra[i]);
    end
    check_eq("t2_done_cnt", 32'(done_cnt), 32'd1);
    check_eq("t2_busy_end", 32'(busy), 32'd0);

    // size = 0 fast path
    databus_ready = 1'b1;
    start_xfer(DIR_EXT2INT, 16'h700, 16'h1, 4'd0, 4'd1, 8'd0);
    repeat (4) step();
    check_eq("t3_done_cnt", 32'(done_cnt), 32'd1);
    check_eq("t3_done_cyc", 32'(done_cyc), 32'd1);
    check_eq("t3_valid_seen", 32'(valid_seen), 32'd0);
    check_eq("t3_req_seen", 32'(req_seen), 32'd0);
    check_eq("t3_busy_seen", 32'(busy_seen), 32'd0);

    // invalid direction behaves like size = 0
    start_xfer(2'b11, 16'h700, 16'h1, 4'd0, 4'd1, 8'd3);
    repeat (4) step();
    check_eq("t3b_done_cnt", 32'(done_cnt), 32'd1);
    check_eq("t3b_done_cyc", 32'(done_cyc), 32'd1);
    check_eq("t3b_valid_seen", 32'(valid_seen), 32'd0);
    check_eq("t3b_req_seen", 32'(req_seen), 32'd0);

    // Address wrap: internal 14,15,0,1; external stride -1
    start_xfer(DIR_EXT2INT, 16'h300, 16'hFFFF, 4'd14, 4'd1, 8'd4);
    wait_done("t4", 20);
    repeat (2) step();
    check_eq("t4_nwr", 32'(wr_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < beat_q.size()) check_eq("t4_beat_addr", beat_q[i].a, t4_ba[i]);
      if (i < wr_q.size()) begin
        check_eq("t4_wr_addr", wr_q[i].a, t4_wa[i]);
        check_eq("t4_wr_data", wr_q[i].d, t4_wd[i]);
      end
    end
    check_eq("t4_done_cyc", 32'(done_cyc), 32'd5);

    // Abort during INT2EXT with ready low
    databus_ready = 1'b0;
    start_xfer(DIR_INT2EXT, 16'h400, 16'h1, 4'd5, 4'd1, 8'd3);
    step();                  // cycle 2
    step(); abort = 1'b1;    // cycle 3
    step(); abort = 1'b0;    // cycle 4
    step();                  // cycle 5
    step(); databus_ready = 1'b1; // cycle 6
    wait_done("t5", 20);
    repeat (4) step();
    check_eq("t5_nbeats", 32'(beat_q.size()), 32'd1);
    if (beat_q.size() > 0) begin
      check_eq("t5_beat_cyc", 32'(beat_q[0].cyc), 32'd6);
      check_eq("t5_beat_addr", beat_q[0].a, 32'h400);
      check_eq("t5_beat_wdata", beat_q[0].d, 32'hC0DE_0005);
    end
    check_eq("t5_nrd", 32'(rd_q.size()), 32'd2);
    check_eq("t5_done_cnt", 32'(done_cnt), 32'd1);
    check_eq("t5_done_cyc", 32'(done_cyc), 32'd7);
    check_eq("t5_req_after_done", 32'(req_after_done), 32'd0);
    check_eq("t5_busy", 32'(busy), 32'd0);

    // Fresh INT2EXT after abort, ready high
    start_xfer(DIR_INT2EXT, 16'h500, 16'h1, 4'd5, 4'd1, 8'd3);
    wait_done("t5b", 20);
    repeat (2) step();
    check_eq("t5b_nbeats", 32'(beat_q.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < beat_q.size()) begin
        check_eq("t5b_beat_cyc", 32'(beat_q[i].cyc), 32'(i + 2));
        check_eq("t5b_beat_wdata", beat_q[i].d, t5_wd[i]);
      end
    end
    check_eq("t5b_done_cyc", 32'(done_cyc), 32'd5);

    // Reset mid-transfer
    start_xfer(DIR_EXT2INT, 16'h600, 16'h1, 4'd0, 4'd1, 8'd8);
    step(); step();          // cycle 3
    mon_en = 1'b0;
    rst = 1'b1;
    step();
    check_eq("t6_busy", 32'(busy), 32'd0);
    check_eq("t6_done", 32'(done), 32'd0);
    check_eq("t6_valid", 32'(databus_valid), 32'd0);
    check_eq("t6_req", 32'(req), 32'd0);
    check_eq("t6_rnw", 32'(rnw), 32'd1);
    check_eq("t6_daddr", 32'(databus_addr), 32'd0);
    check_eq("t6_addr", 32'(addr), 32'd0);
    check_eq("t6_wstrb", 32'(databus_wstrb), 32'd0);
    rst = 1'b0;
    repeat (5) step();
    check_eq("t6_done_cnt", 32'(done_cnt), 32'd0);
    check_eq("t6_busy_after", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
